// File: rtl/param_queue.sv
// Parameterised show-ahead FIFO on a circular buffer; any DEPTH, explicit-compare pointer wrap.
// Optional sticky overflow/underflow flags are built only when PARAM_QUEUE_ERR_EN is defined.
module param_queue #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clock10mhz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CW-1:0]     len_out,
  output logic              empty_out,
  output logic              full_out,
  output logic              afull_out,
  output logic              ovf_out,
  output logic              udf_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              enq_ok, deq_ok;
  logic              empty, full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Status comes from the registered count only, so no request input reaches these outputs.
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    enq_ok   = enqueue_in && (!full || dequeue_in);
    deq_ok   = dequeue_in && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_ok) wr_ptr_d = next_ptr(wr_ptr_q);
    if (deq_ok) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock10mhz or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; an empty count already hides stale words and keeps this a plain RAM.
  always_ff @(posedge clock10mhz) begin
    if (enq_ok) mem[wr_ptr_q] <= data_in;
  end

  assign data_out  = empty ? '0 : mem[rd_ptr_q];
  assign len_out   = count_q;
  assign empty_out = empty;
  assign full_out  = full;
  assign afull_out = (count_q >= CW'(AF_LEVEL));

`ifdef PARAM_QUEUE_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A dropped enqueue or an ignored dequeue latches its flag until the next reset.
  always_comb begin
    ovf_d = ovf_q | (enqueue_in && full && !dequeue_in);
    udf_d = udf_q | (dequeue_in && empty);
  end

  always_ff @(posedge clock10mhz or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_out = ovf_q;
  assign udf_out = udf_q;
`else
  assign ovf_out = 1'b0;
  assign udf_out = 1'b0;
`endif

endmodule

// File: doc/param_queue.md
PARAM_QUEUE -- requirements
Module: param_queue

Interface
REQ-001 Parameter DATA_W, default 8: width of each queued word in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 8: number of storage entries, legal range 2..256, any integer (not only powers of two).
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost-full threshold, legal range 1..DEPTH.
REQ-004 Localparam CW = $clog2(DEPTH+1) shall size the occupancy count.
REQ-005 clock10mhz  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 data_in  in  DATA_W  word to enqueue.
REQ-008 enqueue_in  in  1  enqueue request, sampled each rising edge.
REQ-009 dequeue_in  in  1  dequeue request, sampled each rising edge.
REQ-010 data_out  out  DATA_W  head (oldest) word, show-ahead.
REQ-011 len_out  out  CW  current occupancy, 0..DEPTH.
REQ-012 empty_out  out  1  high when len_out == 0.
REQ-013 full_out  out  1  high when len_out == DEPTH.
REQ-014 afull_out  out  1  high when len_out >= AF_LEVEL.
REQ-015 ovf_out  out  1  sticky overflow flag (see Configuration).
REQ-016 udf_out  out  1  sticky underflow flag (see Configuration).

Function
REQ-017 Storage is a circular buffer of DEPTH x DATA_W with a write pointer, a read pointer, and a CW-bit count.
REQ-018 Accepted enqueue = enqueue_in && (!full_out || dequeue_in): writes data_in at the write pointer and advances the write pointer.
REQ-019 Accepted dequeue = dequeue_in && !empty_out: advances the read pointer.
REQ-020 Each pointer wraps from DEPTH-1 to 0; wrap logic is explicit compare, not power-of-two truncation.
REQ-021 Count update per cycle: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-022 Both requests while empty: the enqueue is accepted, the dequeue is ignored, and the count becomes 1.
REQ-023 Both requests while full: both are accepted, the count stays DEPTH, and the head advances.
REQ-024 Enqueue while full without dequeue: the request is dropped, and storage and pointers are unchanged.
REQ-025 Dequeue while empty: the request is ignored and the state is unchanged.
REQ-026 data_out equals storage[read pointer] combinationally when not empty, and equals 0 when empty.
REQ-027 Latency: a word enqueued at edge N is visible on data_out after edge N if the queue was empty.
REQ-028 len_out, empty_out, full_out and afull_out are derived from the registered count only, with no combinational path from the request inputs.
REQ-029 Storage contents are not cleared by reset; only pointers, count and flags are cleared.

Reset
REQ-030 reset low asynchronously forces: pointers = 0, count = 0, ovf_out = 0, udf_out = 0.
REQ-031 While reset is low the outputs shall be: len_out = 0, empty_out = 1, full_out = 0, afull_out = 0, data_out = 0.
REQ-032 Release of reset is synchronous to clock10mhz; the first accepted operation occurs at the first rising edge with reset high.
REQ-033 Reset asserted mid-operation discards all queued words; requests pending on that edge are ignored.

Configuration
REQ-034 Macro PARAM_QUEUE_ERR_EN selects error-flag logic.
REQ-035 When PARAM_QUEUE_ERR_EN is defined: ovf_out sets on any dropped enqueue (REQ-024) and udf_out sets on any ignored dequeue (REQ-025); both flags clear only on reset.
REQ-036 When PARAM_QUEUE_ERR_EN is undefined: ovf_out and udf_out are tied to 0, no flag registers exist, and all other behaviour is identical.

Verification
REQ-037 DEPTH=8, DATA_W=8: enqueue 0x11..0x88 on 8 cycles -> full_out=1 and len_out=8; then dequeue 8 cycles -> data_out sequence 0x11..0x88, then empty_out=1 and data_out=0.
REQ-038 DEPTH=5: 12 interleaved enqueue/dequeue cycles forcing 3 pointer wraps -> FIFO order preserved and len_out never exceeds 5.
REQ-039 Full queue, enqueue 0xAA + dequeue in the same cycle -> len_out stays at DEPTH, the old head is removed, and 0xAA becomes the tail; empty queue with both requests -> len_out=1 and data_out=0xAA.
REQ-040 With PARAM_QUEUE_ERR_EN: enqueue while full -> ovf_out=1 and persists; dequeue while empty -> udf_out=1; after reset pulse -> both 0. Without the macro -> both stay 0.
REQ-041 AF_LEVEL=6, DEPTH=8: afull_out rises on the edge where len_out reaches 6 and falls when len_out drops to 5.
REQ-042 Assert reset low mid-cycle with len_out=4 -> outputs reach reset values immediately without a clock edge; after release, the first enqueue of 0x5C gives len_out=1 and data_out=0x5C.
